// File: rtl/outlier_pkg.sv
// Shared types and default sizes for the DROR outlier-removal datapath.
package outlier_pkg;
   localparam int N_DEF   = 16;
   localparam int M_DEF   = 32;
   localparam int CN_DEF  = 2;
   localparam int LAT_DEF = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SWEEP, S_DRAIN, S_EMIT, S_NEXT, S_DONE
   } state_e;

   typedef logic [N_DEF-1:0] idx_t;
endpackage

// File: rtl/outlier_emit_arbiter.sv
// Picks the lowest pending core verdict and returns the mask with that bit removed.
module outlier_emit_arbiter #(
   parameter int WIDTH = 2,
   parameter int IW    = 1
) (
   input  logic [WIDTH-1:0] pending,
   output logic             any,
   output logic [IW-1:0]    idx,
   output logic [WIDTH-1:0] rest
);
   logic [WIDTH-1:0] onehot;

   assign any    = |pending;
   assign onehot = pending & ~(pending - WIDTH'(1));
   assign rest   = pending & ~onehot;

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++)
         if (onehot[i]) idx = IW'(i);
   end
endmodule

// File: rtl/outlier_sweep_scheduler.sv
// Sequences test-point groups, feeder window sweeps, core drain and outlier index serialisation.
module outlier_sweep_scheduler
   import outlier_pkg::*;
#(
   parameter int N           = N_DEF,
   parameter int M           = M_DEF,
   parameter int CORE_NUMBER = CN_DEF,
   parameter int CORE_LAT    = LAT_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [N-1:0]           point_cloud_size,
   output logic [N-1:0]           feeder_pos,
   output logic                   feeder_valid,
   output logic [M-1:0]           feeder_lane_valid,
   output logic [N-1:0]           point_pos,
   output logic [CORE_NUMBER-1:0] core_active,
   output logic                   core_clear,
   input  logic [CORE_NUMBER-1:0] core_outlier,
   output logic                   fifo_push,
   output logic [N-1:0]           fifo_data,
   input  logic                   fifo_full,
   output logic                   busy,
   output logic                   done,
   output logic [N-1:0]           outlier_count
);
   localparam int IW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;
   localparam int CW = $clog2(CORE_LAT + 1);

   state_e                 state_q, state_d;
   logic [N-1:0]           size_q, size_d;
   logic [N-1:0]           feeder_pos_q, feeder_pos_d;
   logic [N-1:0]           point_pos_q, point_pos_d;
   logic [N-1:0]           outlier_count_q, outlier_count_d;
   logic [CORE_NUMBER-1:0] pending_q, pending_d;
   logic [CW-1:0]          lat_cnt_q, lat_cnt_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   core_clear_q, core_clear_d, feeder_valid_q, feeder_valid_d;

   logic                   arb_any;
   logic [IW-1:0]          arb_idx;
   logic [CORE_NUMBER-1:0] arb_rest;
   logic [N:0]             fpos_end, ppos_end, size_w;
   logic [CORE_NUMBER-1:0] verdict;

   outlier_emit_arbiter #(.WIDTH(CORE_NUMBER), .IW(IW)) u_arb (
      .pending (pending_q),
      .any     (arb_any),
      .idx     (arb_idx),
      .rest    (arb_rest)
   );

   // Bounds are compared one bit wider so a cloud near 2^N never wraps.
   assign size_w   = {1'b0, size_q};
   assign fpos_end = {1'b0, feeder_pos_q} + (N+1)'(M);
   assign ppos_end = {1'b0, point_pos_q} + (N+1)'(CORE_NUMBER);
   assign verdict  = core_outlier & core_active;

   always_comb begin
      for (int i = 0; i < M; i++)
         feeder_lane_valid[i] = feeder_valid_q && (({1'b0, feeder_pos_q} + (N+1)'(i)) < size_w);
      for (int i = 0; i < CORE_NUMBER; i++)
         core_active[i] = ({1'b0, point_pos_q} + (N+1)'(i)) < size_w;
   end

   assign fifo_push     = (state_q == S_EMIT) && arb_any && !fifo_full;
   assign fifo_data     = point_pos_q + N'(arb_idx);
   assign feeder_pos    = feeder_pos_q;
   assign feeder_valid  = feeder_valid_q;
   assign point_pos     = point_pos_q;
   assign core_clear    = core_clear_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign outlier_count = outlier_count_q;

   always_comb begin
      state_d         = state_q;
      size_d          = size_q;
      feeder_pos_d    = feeder_pos_q;
      point_pos_d     = point_pos_q;
      outlier_count_d = outlier_count_q;
      pending_d       = pending_q;
      lat_cnt_d       = lat_cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               size_d          = point_cloud_size;
               point_pos_d     = '0;
               feeder_pos_d    = '0;
               outlier_count_d = '0;
               state_d         = (point_cloud_size == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            feeder_pos_d = '0;
            state_d      = S_SWEEP;
         end
         S_SWEEP: begin
            if (fpos_end >= size_w) begin
               lat_cnt_d = '0;
               state_d   = S_DRAIN;
            end else begin
               feeder_pos_d = feeder_pos_q + N'(M);
            end
         end
         S_DRAIN: begin
            if (lat_cnt_q == CW'(CORE_LAT - 1)) begin
               pending_d = verdict;
               state_d   = (verdict != '0) ? S_EMIT : S_NEXT;
            end else begin
               lat_cnt_d = lat_cnt_q + CW'(1);
            end
         end
         S_EMIT: begin
            if (!arb_any) begin
               state_d = S_NEXT;
            end else if (!fifo_full) begin
               pending_d       = arb_rest;
               outlier_count_d = outlier_count_q + N'(1);
               if (arb_rest == '0) state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (ppos_end >= size_w) begin
               state_d = S_DONE;
            end else begin
               point_pos_d = point_pos_q + N'(CORE_NUMBER);
               state_d     = S_CLEAR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Status outputs track the state being entered so they register with it.
      busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d         = (state_d == S_DONE);
      core_clear_d   = (state_d == S_CLEAR);
      feeder_valid_d = (state_d == S_SWEEP);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         size_q          <= '0;
         feeder_pos_q    <= '0;
         point_pos_q     <= '0;
         outlier_count_q <= '0;
         pending_q       <= '0;
         lat_cnt_q       <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         core_clear_q    <= 1'b0;
         feeder_valid_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         size_q          <= size_d;
         feeder_pos_q    <= feeder_pos_d;
         point_pos_q     <= point_pos_d;
         outlier_count_q <= outlier_count_d;
         pending_q       <= pending_d;
         lat_cnt_q       <= lat_cnt_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         core_clear_q    <= core_clear_d;
         feeder_valid_q  <= feeder_valid_d;
      end
   end
endmodule
